// File: rtl/ex_alu_unit.sv
// ex_alu_unit: execute-stage datapath for an RV32IM pipeline.
//   Base ALU ops and all multiplies finish in one cycle. Divide/remainder
//   use an iterative restoring radix-2 divider that takes XLEN steps.
//   Results and destination tags are registered into the EX/MEM boundary.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operation handshake (in_ready = state IDLE)
//   alu_ctrl              {func7[0], func7[5], func3} from the decoder
//   op_a, op_b, in_rd     operands and destination tag
//   flush                 kill the in-flight or presented operation
//   out_valid             one-cycle result strobe
//   out_result, out_rd    registered result and tag (held between writes)
module ex_alu_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      in_rd,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_rd
);

  localparam int CW = $clog2(XLEN + 1);
  localparam int SW = $clog2(XLEN);
  localparam int PW = 2 * XLEN + 2;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic            neg_q_q, neg_q_d;
  logic            neg_r_q, neg_r_d;
  logic            is_rem_q, is_rem_d;
  logic [4:0]      rd_q, rd_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_result_q, out_result_d;
  logic [4:0]      out_rd_q, out_rd_d;

  // ---------------- base ALU ----------------
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] base_res;

  assign shamt = op_b[SW-1:0];

  always_comb begin
    base_res = '0;
    unique case (alu_ctrl[2:0])
      3'b000: base_res = alu_ctrl[3] ? (op_a - op_b) : (op_a + op_b);
      3'b001: base_res = op_a << shamt;
      3'b010: base_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      3'b011: base_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      3'b100: base_res = op_a ^ op_b;
      3'b101: base_res = alu_ctrl[3] ? XLEN'($signed(op_a) >>> shamt)
                                     : (op_a >> shamt);
      3'b110: base_res = op_a | op_b;
      default: base_res = op_a & op_b;
    endcase
  end

  // ---------------- multiplier ----------------
  // Operands are extended to the full product width so one signed multiply
  // covers mul/mulh/mulhsu/mulhu; the low 2*XLEN bits are exact for all.
  logic            mul_a_sgn, mul_b_sgn;
  logic [PW-1:0]   mul_a, mul_b, mul_p;
  logic [XLEN-1:0] mul_res;
  logic            unused_mul;

  assign mul_a_sgn = (alu_ctrl[1:0] != 2'b11) & op_a[XLEN-1]; // mulh, mulhsu
  assign mul_b_sgn = (alu_ctrl[1:0] == 2'b01) & op_b[XLEN-1]; // mulh only
  assign mul_a = {{(XLEN+2){mul_a_sgn}}, op_a};
  assign mul_b = {{(XLEN+2){mul_b_sgn}}, op_b};
  assign mul_p = mul_a * mul_b;
  assign mul_res = (alu_ctrl[1:0] == 2'b00) ? mul_p[XLEN-1:0]
                                            : mul_p[2*XLEN-1:XLEN];
  assign unused_mul = ^mul_p[PW-1:2*XLEN];

  // ---------------- divider setup ----------------
  logic            dv_signed, dv_rem, dv_zero, dv_ovf;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag, dv_fast;

  assign dv_signed = ~alu_ctrl[0];
  assign dv_rem    = alu_ctrl[1];
  assign dv_zero   = (op_b == '0);
  assign dv_ovf    = dv_signed && (op_a == {1'b1, {(XLEN-1){1'b0}}})
                                && (op_b == '1);
  assign a_neg     = dv_signed & op_a[XLEN-1];
  assign b_neg     = dv_signed & op_b[XLEN-1];
  assign a_mag     = a_neg ? (-op_a) : op_a;
  assign b_mag     = b_neg ? (-op_b) : op_b;
  // Divide-by-zero and signed overflow resolve without iterating.
  assign dv_fast   = dv_zero ? (dv_rem ? op_a : '1)
                             : (dv_rem ? '0 : op_a);

  // ---------------- divider step ----------------
  logic [XLEN:0]   rem_sh, rem_diff;

  assign rem_sh   = {rem_q, quo_q[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, dvsr_q};

  // ---------------- control / next state ----------------
  logic accept, is_m, is_div;

  assign accept = in_valid && (state_q == S_IDLE) && !flush;
  assign is_m   = alu_ctrl[4];
  assign is_div = is_m && alu_ctrl[2];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    dvsr_d       = dvsr_q;
    neg_q_d      = neg_q_q;
    neg_r_d      = neg_r_q;
    is_rem_d     = is_rem_q;
    rd_d         = rd_q;
    out_valid_d  = 1'b0;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!is_div) begin
            out_valid_d  = 1'b1;
            out_result_d = is_m ? mul_res : base_res;
            out_rd_d     = in_rd;
          end else if (dv_zero || dv_ovf) begin
            out_valid_d  = 1'b1;
            out_result_d = dv_fast;
            out_rd_d     = in_rd;
          end else begin
            state_d  = S_DIV;
            cnt_d    = CW'(XLEN);
            rem_d    = '0;
            quo_d    = a_mag;
            dvsr_d   = b_mag;
            neg_q_d  = a_neg ^ b_neg;
            neg_r_d  = a_neg;
            is_rem_d = dv_rem;
            rd_d     = in_rd;
          end
        end
      end
      S_DIV: begin
        // Restoring step: quotient register doubles as the dividend shifter.
        if (!rem_diff[XLEN]) begin
          rem_d = rem_diff[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid_d  = 1'b1;
        out_result_d = is_rem_q ? (neg_r_q ? (-rem_q) : rem_q)
                                : (neg_q_q ? (-quo_q) : quo_q);
        out_rd_d     = rd_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush aborts any division and suppresses every write this edge.
    if (flush) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      out_valid_d  = 1'b0;
      out_result_d = out_result_q;
      out_rd_d     = out_rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvsr_q       <= '0;
      neg_q_q      <= 1'b0;
      neg_r_q      <= 1'b0;
      is_rem_q     <= 1'b0;
      rd_q         <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      dvsr_q       <= dvsr_d;
      neg_q_q      <= neg_q_d;
      neg_r_q      <= neg_r_d;
      is_rem_q     <= is_rem_d;
      rd_q         <= rd_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_rd     = out_rd_q;

endmodule

// File: tb/tb_ex_alu_unit.sv
module tb_ex_alu_unit;
  logic        clk, rst, in_valid, in_ready, flush, out_valid;
  logic [4:0]  alu_ctrl, in_rd, out_rd;
  logic [31:0] op_a, op_b, out_result;

  int n_cmp = 0;
  int n_err = 0;

  ex_alu_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .in_rd(in_rd),
    .flush(flush), .out_valid(out_valid), .out_result(out_result),
    .out_rd(out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    alu_ctrl = c; op_a = a; op_b = b; in_rd = rd; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Single-cycle op: strobe and result right after the accept edge,
  // strobe gone one cycle later.
  task automatic one(input string tag, input logic [4:0] c, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp);
    issue(c, a, b, 5'd3);
    chk({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
    chk(tag, out_result, exp);
    step();
    chk({tag, "_vld_drop"}, {31'b0, out_valid}, 32'd0);
  endtask

  // Called right after an accept edge of an iterating divide.
  task automatic wait_div(input string tag, input logic [31:0] exp, input logic [4:0] rd);
    int cyc = 0;
    logic rdy_seen = 1'b0;
    while (!out_valid && cyc < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      step();
      cyc++;
    end
    chk({tag, "_lat"}, cyc, 32'd33);
    chk({tag, "_rdy_low"}, {31'b0, rdy_seen}, 32'd0);
    chk(tag, out_result, exp);
    chk({tag, "_rd"}, {27'b0, out_rd}, {27'b0, rd});
    chk({tag, "_rdy_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  task automatic no_valid(input string tag, input int n);
    logic seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    chk(tag, {31'b0, seen}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    alu_ctrl = '0; op_a = '0; op_b = '0; in_rd = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_rd", {27'b0, out_rd}, 32'd0);

    // flush with in_valid in IDLE: nothing accepted
    alu_ctrl = 5'b00000; op_a = 32'd1; op_b = 32'd2; in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("idle_flush_vld", {31'b0, out_valid}, 32'd0);
    chk("idle_flush_res", out_result, 32'd0);

    one("add",   5'b00000, 32'd5, 32'd7, 32'd12);
    one("sub",   5'b01000, 32'd5, 32'd7, 32'hFFFFFFFE);
    one("sra",   5'b01101, 32'h80000000, 32'd4, 32'hF8000000);
    one("srl",   5'b00101, 32'h80000000, 32'd4, 32'h08000000);
    one("sll",   5'b00001, 32'h00000003, 32'd33, 32'h00000006);
    one("slt",   5'b00010, 32'hFFFFFFFF, 32'd1, 32'd1);
    one("sltu",  5'b00011, 32'hFFFFFFFF, 32'd1, 32'd0);
    one("xor",   5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0);
    one("and",   5'b00111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000);
    one("mulh",  5'b10001, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF);
    one("mulhu", 5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    one("mul",   5'b10000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    one("mulhsu",5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);

    one("divu0", 5'b10101, 32'd123, 32'd0, 32'hFFFFFFFF);
    one("rem0",  5'b10110, 32'd123, 32'd0, 32'd123);
    one("divov", 5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    one("remov", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'd0);

    // iterative divide then back-to-back rem in the cycle in_ready rises
    issue(5'b10100, 32'hFFFFFFF9, 32'd2, 5'd9);
    chk("div_rdy0", {31'b0, in_ready}, 32'd0);
    wait_div("div", 32'hFFFFFFFD, 5'd9);
    issue(5'b10110, 32'hFFFFFFF9, 32'd2, 5'd17);
    wait_div("rem", 32'hFFFFFFFF, 5'd17);
    issue(5'b10101, 32'd100, 32'd7, 5'd4);
    wait_div("divu", 32'd14, 5'd4);

    // flush ten cycles into a divide
    issue(5'b10100, 32'd1000, 32'd3, 5'd12);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_rdy", {31'b0, in_ready}, 32'd1);
    chk("flush_vld", {31'b0, out_valid}, 32'd0);
    no_valid("flush_never", 40);

    // reset mid-divide
    issue(5'b10100, 32'd1000, 32'd3, 5'd7);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstd_vld", {31'b0, out_valid}, 32'd0);
    chk("rstd_res", out_result, 32'd0);
    chk("rstd_rd", {27'b0, out_rd}, 32'd0);
    chk("rstd_rdy", {31'b0, in_ready}, 32'd1);
    no_valid("rstd_never", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ex_alu_unit.md
Name: ex_alu_unit

Overview:
Execute-stage datapath of the pipelined RV32IM core, directly downstream of the ALU control decoder. It consumes the 5-bit ALU control code together with the two operands, computes RV32I ALU results and RV32M multiply results in one cycle, and computes divide/remainder results with an iterative radix-2 divider. Results and the destination tag are registered into the EX/MEM boundary. The unit stalls the upstream pipeline while a division is in progress.

Parameters:
XLEN, 32, operand/result width; divider iteration count equals XLEN.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operation presented this cycle
in_ready  out  1  unit can accept; combinational, equals (state==IDLE)
alu_ctrl  in  5  {func70, func75, func3} control code from decoder
op_a  in  XLEN  operand A (rs1 or PC)
op_b  in  XLEN  operand B (rs2 or immediate)
in_rd  in  5  destination register tag
flush  in  1  kill in-flight and presented operation
out_valid  out  1  registered one-cycle result strobe
out_result  out  XLEN  registered result
out_rd  out  5  registered destination tag

Behaviour:
- Decode: alu_ctrl[4]=0 selects base ops on alu_ctrl[2:0]; alu_ctrl[3] selects sub (000) or sra (101), otherwise ignored. Base ops: 000 add/sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and.
- Shift amount is op_b[4:0]. slt/sltu return 0 or 1, zero-extended. Add/sub wrap modulo 2^XLEN.
- alu_ctrl[4]=1 selects M ops; alu_ctrl[3] is ignored. M ops: 000 mul (low), 001 mulh (s×s), 010 mulhsu (s×u), 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- Accept: an operation is accepted on an edge where in_valid && in_ready && !flush.
- Single-cycle ops (all base, all mul, div fast paths): the result is written at the accept edge. out_valid=1 for the following cycle only.
- Div fast paths (single-cycle):
  - divisor 0: quotient all ones, remainder = op_a.
  - signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF, signed ops only): quotient 0x80000000, remainder 0.
- Normal div/rem:
  - Accept edge: latch operand magnitudes, result-sign flags, op kind and in_rd. Go IDLE→DIV with counter=XLEN.
  - DIV: one restoring shift/subtract step per edge, counter decrements; XLEN edges total.
  - Counter reaching 0: go DIV→DONE.
  - DONE edge: apply sign fix (quotient negative iff signs differ; remainder takes the dividend's sign), write out_result/out_rd, set out_valid, go →IDLE.
  - out_valid is therefore visible after edge k+XLEN+1 for an accept at edge k.
  - in_ready=0 throughout DIV and DONE.
- States: IDLE, DIV, DONE. Only legal transitions: IDLE→DIV, DIV→DIV, DIV→DONE, DONE→IDLE, and any→IDLE on flush or rst.
- No downstream backpressure: out_valid is a pulse and out_* hold their value until the next write.
- flush:
  - In IDLE: nothing accepted.
  - In DIV/DONE: abort, go →IDLE, no out_valid.
  - flush on the DONE edge suppresses the write.
  - out_valid is 0 in the cycle after any flush edge.
- Reset: state=IDLE, counter=0, out_valid=0, out_result=0, out_rd=0. in_ready=1 in the cycle after reset. Reset mid-division discards the operation with no out_valid.
- Cycles without an accepted single-cycle op or a DONE write drive out_valid=0.

Test Plan:
- add/sub: ctrl=00000, a=5, b=7 → out_result=12, out_valid next cycle. ctrl=01000 → 0xFFFFFFFE.
- Shifts/compares: sra ctrl=01101, a=0x80000000, b=4 → 0xF8000000. srl ctrl=00101 same operands → 0x08000000. slt a=-1, b=1 → 1; sltu same operands → 0.
- Multiply: mulh a=-2, b=3 → 0xFFFFFFFF. mulhu a=b=0xFFFFFFFF → 0xFFFFFFFE. mul same operands → 0x00000001. All with 1-cycle latency.
- Divide: div a=-7, b=2 → 0xFFFFFFFD and rem → 0xFFFFFFFF. out_valid appears 33 edges after accept, in_ready low for those cycles, and out_rd matches in_rd. Back-to-back accept in the same cycle in_ready rises.
- Corner divides: divu b=0 → 0xFFFFFFFF, rem b=0 → a. div 0x80000000/-1 → 0x80000000, rem → 0. Each has 1-cycle latency.
- Flush/reset: flush 10 cycles into a div → in_ready=1 next cycle, no out_valid ever for that op. rst mid-div → all outputs 0. in_valid with flush in IDLE → no out_valid.
